// File: rtl/count_rr_scheduler_pkg.sv
// Shared types and defaults for the count round-robin scheduler.
package count_sched_pkg;

    typedef enum logic {
        IDLE,
        UPDATE
    } state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 8;

endpackage

// File: rtl/count_rr_scheduler_if.sv
// Request/ack, status and read-port bundle between the event sources and the scheduler.
interface count_rr_scheduler_if
    import count_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SEL_W   = $clog2(NUM_REQ)
);
    logic               count_en;
    logic               clr;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ack;
    logic               busy;
    logic [NUM_REQ-1:0] ovf;
    logic [SEL_W-1:0]   rd_sel;
    logic [WIDTH-1:0]   rd_data;

    modport master (
        output count_en, clr, req, rd_sel,
        input  ack, busy, ovf, rd_data
    );

    modport slave (
        input  count_en, clr, req, rd_sel,
        output ack, busy, ovf, rd_data
    );
endinterface

// File: rtl/count_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr_i, wrapping.
module rr_pick #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [SEL_W-1:0] idx_o
);
    logic [SEL_W-1:0] cand;

    // Walk from the farthest candidate back to the nearest so the nearest one wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = N; k >= 1; k--) begin
            cand = SEL_W'((int'(ptr_i) + k) % N);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end
endmodule

// File: rtl/count_rr_scheduler.sv
// Per-requester event counters sharing one incrementer under round-robin arbitration.
// state  | meaning
// IDLE   | waiting for count_en and a request; picks the next winner
// UPDATE | ack/busy asserted for grant_q; counter increments at the closing edge
module count_rr_scheduler
    import count_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF
) (
    input logic                 clock,
    input logic                 reset,
    count_rr_scheduler_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_REQ);

    state_e             state_q;
    logic [SEL_W-1:0]   grant_q;
    logic [SEL_W-1:0]   rr_ptr_q;
    logic [WIDTH-1:0]   cnt_q [NUM_REQ];
    logic [NUM_REQ-1:0] ovf_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               busy_q;

    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;
    logic [WIDTH-1:0]   cnt_d;
    logic               wrap_d;
    logic [SEL_W:0]     rd_sel_ext;

    rr_pick #(
        .N     (NUM_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req_i   (bus.req),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign cnt_d  = cnt_q[grant_q] + WIDTH'(1);
    assign wrap_d = &cnt_q[grant_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= SEL_W'(NUM_REQ - 1);
            ovf_q    <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.count_en && pick_valid) begin
                        grant_q <= pick_idx;
                        ack_q   <= NUM_REQ'(1) << pick_idx;
                        busy_q  <= 1'b1;
                        state_q <= UPDATE;
                    end
                end
                UPDATE: begin
                    cnt_q[grant_q] <= cnt_d;
                    if (wrap_d) ovf_q[grant_q] <= 1'b1;
                    rr_ptr_q <= grant_q;
                    ack_q    <= '0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // Clear overrides any increment landing on the same edge.
            if (bus.clr) begin
                ovf_q <= '0;
                for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
            end
        end
    end

    assign rd_sel_ext  = {1'b0, bus.rd_sel};
    assign bus.rd_data = (rd_sel_ext < (SEL_W+1)'(NUM_REQ)) ? cnt_q[bus.rd_sel] : '0;
    assign bus.ack     = ack_q;
    assign bus.busy    = busy_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_count_rr_scheduler.sv
// Self-checking bench: cycle model feeds an expected-output queue checked after each edge.
module tb_count_rr_scheduler;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    count_rr_scheduler_if #(.NUM_REQ(4), .WIDTH(8)) bus ();

    count_rr_scheduler #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0] ack;
        logic       busy;
        logic [3:0] ovf;
        logic [7:0] rd;
    } exp_t;

    exp_t sb[$];
    logic [3:0] ack_log[$];

    int n_chk = 0;
    int n_err = 0;

    logic       m_busy;
    int         m_grant;
    int         m_ptr;
    int         m_cnt[4];
    logic [3:0] m_ovf;
    logic [3:0] sticky;
    int         busy_cycles;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        if (reset) begin
            m_busy = 1'b0;
            m_grant = 0;
            m_ptr = 3;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_ovf = '0;
        end else begin
            if (m_busy) begin
                if (m_cnt[m_grant] == 255) m_ovf[m_grant] = 1'b1;
                m_cnt[m_grant] = (m_cnt[m_grant] + 1) % 256;
                m_ptr = m_grant;
                m_busy = 1'b0;
            end else if (bus.count_en && (|bus.req)) begin
                for (int k = 4; k >= 1; k--)
                    if (bus.req[(m_ptr + k) % 4]) m_grant = (m_ptr + k) % 4;
                m_busy = 1'b1;
            end
            if (bus.clr) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
                m_ovf = '0;
            end
        end
        e.ack  = m_busy ? (4'b0001 << m_grant) : 4'b0000;
        e.busy = m_busy;
        e.ovf  = m_ovf;
        e.rd   = 8'(m_cnt[bus.rd_sel]);
        sb.push_back(e);

        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk("ack", 32'(bus.ack), 32'(e.ack));
        chk("busy", 32'(bus.busy), 32'(e.busy));
        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
        chk("rd_data", 32'(bus.rd_data), 32'(e.rd));
        if (bus.busy) busy_cycles++;
        if (bus.ack != 4'b0000) ack_log.push_back(bus.ack);
        bus.req = bus.req & ~(bus.ack & ~sticky);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic read_chk(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        bus.rd_sel = sel;
        #1;
        chk(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    initial begin
        logic [3:0] rr_order[8];
        rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        reset = 1'b1;
        bus.count_en = 1'b1;
        bus.clr = 1'b0;
        bus.req = '0;
        bus.rd_sel = '0;
        sticky = '0;

        // reset, then a single request on channel 0
        steps(2);
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_rd", 32'(bus.rd_data), 32'h0);
        reset = 1'b0;
        bus.req = 4'b0001;
        busy_cycles = 0;
        step();
        chk("single_ack", 32'(bus.ack), 32'h1);
        steps(3);
        chk("single_busy_len", 32'(busy_cycles), 32'd1);
        read_chk("single_cnt0", 2'd0, 8'd1);

        // round-robin fairness
        reset = 1'b1;
        step();
        reset = 1'b0;
        ack_log.delete();
        sticky = 4'b1111;
        bus.req = 4'b1111;
        steps(16);
        bus.req = '0;
        sticky = '0;
        chk("rr_count", 32'(ack_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < ack_log.size(); i++)
            chk("rr_order", 32'(ack_log[i]), 32'(rr_order[i]));
        for (int i = 0; i < 4; i++) read_chk("rr_cnt", 2'(i), 8'd2);

        // wrap / overflow on channel 2
        reset = 1'b1;
        step();
        reset = 1'b0;
        sticky = 4'b0100;
        bus.req = 4'b0100;
        steps(512);
        read_chk("wrap_cnt2", 2'd2, 8'd0);
        chk("wrap_ovf", 32'(bus.ovf), 32'h4);
        steps(2);
        bus.req = '0;
        sticky = '0;
        read_chk("wrap_cnt2_after", 2'd2, 8'd1);
        chk("wrap_ovf_sticky", 32'(bus.ovf), 32'h4);

        // clr during the ack cycle
        reset = 1'b1;
        step();
        reset = 1'b0;
        sticky = 4'b0010;
        bus.req = 4'b0010;
        steps(10);
        bus.req = '0;
        sticky = '0;
        read_chk("clr_pre_cnt1", 2'd1, 8'd5);
        bus.req = 4'b0010;
        step();
        chk("clr_ack", 32'(bus.ack), 32'h2);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        read_chk("clr_cnt1", 2'd1, 8'd0);
        chk("clr_ovf", 32'(bus.ovf), 32'h0);

        // count_en gating
        bus.count_en = 1'b0;
        bus.req = 4'b0100;
        ack_log.delete();
        bus.rd_sel = 2'd2;
        steps(10);
        chk("gate_no_ack", 32'(ack_log.size()), 32'd0);
        read_chk("gate_cnt2", 2'd2, 8'd0);
        bus.count_en = 1'b1;
        step();
        chk("gate_ack", 32'(bus.ack), 32'h4);
        step();
        read_chk("gate_cnt2_after", 2'd2, 8'd1);

        // reset in the middle of an update on channel 3
        reset = 1'b1;
        step();
        reset = 1'b0;
        sticky = 4'b1000;
        bus.req = 4'b1000;
        steps(14);
        bus.req = '0;
        sticky = '0;
        read_chk("mid_pre_cnt3", 2'd3, 8'd7);
        bus.req = 4'b1000;
        step();
        chk("mid_ack3", 32'(bus.ack), 32'h8);
        reset = 1'b1;
        bus.req = '0;
        step();
        reset = 1'b0;
        read_chk("mid_cnt3", 2'd3, 8'd0);
        chk("mid_ack", 32'(bus.ack), 32'h0);
        chk("mid_busy", 32'(bus.busy), 32'h0);
        bus.req = 4'b1001;
        step();
        chk("mid_first_grant", 32'(bus.ack), 32'h1);
        steps(3);
        bus.req = '0;
        step();
        read_chk("mid_cnt0", 2'd0, 8'd1);
        read_chk("mid_cnt3_final", 2'd3, 8'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
